sample_packer: RTL and testbench
================================

Name: sample_packer

Overview:
- Sits between the 2-bit quantizers and packet_streamer, in the source_clk (clk64) domain.
- Takes one I/Q quantized sample set per valid cycle from up to three RF channels.
- Selects 1, 2 or 3 channels by mode and bit-packs the sign/magnitude fields MSB-first into 16-bit words.
- Emits each word with a one-cycle strobe that drives packet_streamer's source_data/source_en directly.
- Replaces the fixed two-channel shift register in top, and adds runtime channel-count selection and a word counter for CPU readback.

Parameters:
- NCH, 3, number of RF channels presented at the inputs.
- SW, 2, bits per I or Q quantized field.
- WORD_W, 16, output word width.

Ports:
- clk  in  1  source clock (clk64).
- reset_n  in  1  synchronous active-low reset.
- in_i  in  NCH*SW  I fields; ch1 at [1:0], ch2 at [3:2], ch3 at [5:4].
- in_q  in  NCH*SW  Q fields; same layout.
- in_valid  in  1  sample set present this cycle.
- enable  in  1  streaming enable (from out_port_21).
- mode  in  2  0=ch1, 1=ch1+ch2, 2=ch1..ch3, 3=reserved (treated as 2).
- test_pattern  in  1  test-pattern select; ignored unless macro defined.
- out_data  out  WORD_W  packed word.
- out_en  out  1  one-cycle strobe, out_data valid.
- sync  out  1  one-cycle pulse on every packer restart.
- word_count  out  16  words emitted, wraps.

Behaviour:
- Interface: one clock clk; reset is synchronous and active-low (reset_n), sampled on posedge clk.
- Reset values: out_data=0, out_en=0, sync=0, word_count=0, fill=0, accumulator=0, active_mode=1.
- Bits per sample B: mode0=4, mode1=8, mode2/3=12.
- Field order within a sample, MSB first: ch1_i, ch1_q, ch2_i, ch2_q, ch3_i, ch3_q (truncated per mode).
- Accumulator: 28 bits, fill counter 0..15 between words.
- On in_valid & enable with no resync: acc <= (acc<<B)|sample, fill += B.
- If fill+B >= 16: out_data <= bits [fill+B-1 : fill+B-16] of the new acc, out_en <= 1 next cycle, fill <= fill+B-16.
- Latency: out_en asserts on the cycle after the in_valid that completes the word.
- Throughput: at most one word per cycle; max 12 bits in per cycle, so no overflow is possible and there is no backpressure.
- out_data holds its last value when out_en=0.
- word_count increments on each out_en and wraps 0xFFFF->0.
- Resync: when mode != active_mode (mode 3 compared as 2), that cycle clear fill, load active_mode, drop that cycle's sample, and pulse sync the next cycle. Partial bits are discarded; no partial word is emitted.
- enable=0: fill cleared, in_valid ignored, out_en=0. word_count and active_mode are held.
- enable rising: the stream restarts word-aligned and sync pulses once.
- Priority: reset > enable low > resync > normal packing.
- in_valid gaps: state is held, with no timeout or flush.

Optional Feature:
- Macro SAMPLE_PACKER_TEST_PATTERN_EN.
- Defined: when test_pattern=1, each field takes the low SW bits of a free-running per-sample counter incremented on accepted in_valid. Every field in a sample shares the same value. Counter resets to 0 on reset_n and on resync.
- Undefined: test_pattern is ignored, no counter logic is built, and live samples always pass.

Decomposition:
- Package sample_packer_pkg holds:
  - MODE_1CH=0, MODE_2CH=1, MODE_3CH=2.
  - WORD_W=16, ACC_W=28.
  - Bits-per-sample function of mode.
- One sub-module, sample_select: combinational mux producing a 12-bit left-justified sample vector and B from active_mode, in_i/in_q and the test pattern.

Test Plan:
- Mode 1, ch1 i=01 q=10, ch2 i=11 q=00, 4 consecutive valid cycles -> out_en twice, out_data=0x6C6C each, word_count=2.
- Mode 2, every sample ch1=10/10, ch2=10/11, ch3=11/00 (0xABC), 4 valids -> words 0xABCA, 0xBCAB, 0xCABC, then fill=0.
- Mode 0, ch1 i=11 q=01, 8 valids -> two words 0xDDDD; in_valid toggling every other cycle gives the same words, spaced 8 cycles apart.
- Mode 1, after 1 valid change mode to 2 with in_valid high -> sync pulse, that sample dropped, no partial word, next word built from fresh mode-2 samples.
- enable dropped mid-word then raised -> no out_en while low, sync once on rise, word_count unchanged across the gap; word_count preset near 0xFFFF wraps to 0.
- reset_n low for 1 cycle mid-word -> all outputs 0 next cycle, active_mode=1. With SAMPLE_PACKER_TEST_PATTERN_EN, mode 0 and test_pattern=1 -> first word 0x05AF (fields 00,01,10,11 per sample).

Source files
------------

// File: rtl/sample_packer_pkg.sv
// Constants and helpers shared by the I/Q sample packer and its channel selector.
package sample_packer_pkg;

  localparam logic [1:0] MODE_1CH = 2'd0;
  localparam logic [1:0] MODE_2CH = 2'd1;
  localparam logic [1:0] MODE_3CH = 2'd2;

  localparam int WORD_W   = 16;
  localparam int ACC_W    = 28;
  localparam int SAMPLE_W = 12;
  localparam int FILL_W   = 4;
  localparam int SUM_W    = 5;

  // Mode 3 is reserved and behaves exactly like the three-channel mode.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == 2'd3) ? MODE_3CH : mode;
  endfunction

  function automatic logic [3:0] bits_per_sample(input logic [1:0] mode);
    case (norm_mode(mode))
      MODE_1CH: return 4'd4;
      MODE_2CH: return 4'd8;
      default:  return 4'd12;
    endcase
  endfunction

endpackage

// File: rtl/sample_packer_select.sv
// Channel selector: builds a left-justified sample (ch1_i first) truncated to the
// active mode, optionally substituting a test-pattern value into every field.
module sample_select #(
  parameter int NCH = 3,
  parameter int SW  = 2
) (
  input  logic [1:0]                            active_mode,
  input  logic [NCH*SW-1:0]                     in_i,
  input  logic [NCH*SW-1:0]                     in_q,
  input  logic                                  use_pattern,
  input  logic [SW-1:0]                         pattern,
  output logic [sample_packer_pkg::SAMPLE_W-1:0] sample,
  output logic [3:0]                            bits
);
  import sample_packer_pkg::*;

  logic [SAMPLE_W-1:0] full;
  logic [SAMPLE_W-1:0] keep;

  always_comb begin
    full = '0;
    for (int c = 0; c < NCH; c++) begin
      full[SAMPLE_W-1-2*SW*c -: SW]    = use_pattern ? pattern : in_i[c*SW +: SW];
      full[SAMPLE_W-1-2*SW*c-SW -: SW] = use_pattern ? pattern : in_q[c*SW +: SW];
    end
    bits   = bits_per_sample(active_mode);
    // Fields belonging to channels beyond the active mode are zeroed.
    keep   = ~({SAMPLE_W{1'b1}} >> bits);
    sample = full & keep;
  end

endmodule

// File: rtl/sample_packer.sv
// Packs 1..3 channels of 2-bit I/Q fields MSB-first into 16-bit words with a strobe.
// Optional build macro SAMPLE_PACKER_TEST_PATTERN_EN adds a per-sample counting test pattern.
module sample_packer #(
  parameter int NCH    = 3,
  parameter int SW     = 2,
  parameter int WORD_W = sample_packer_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCH*SW-1:0] in_i,
  input  logic [NCH*SW-1:0] in_q,
  input  logic              in_valid,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              test_pattern,
  output logic [WORD_W-1:0] out_data,
  output logic              out_en,
  output logic              sync,
  output logic [15:0]       word_count
);
  import sample_packer_pkg::*;

  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_next;
  logic [FILL_W-1:0]   fill_q;
  logic [SUM_W-1:0]    fill_sum;
  logic [1:0]          active_mode_q;
  logic [1:0]          mode_norm;
  logic                enable_q;
  logic                resync;
  logic                rise;
  logic                take;
  logic                word_done;
  logic [SAMPLE_W-1:0] sample_lj;
  logic [3:0]          bits;
  logic [3:0]          rshift;
  logic [WORD_W-1:0]   word_p0;
  logic [WORD_W-1:0]   data_p1;
  logic                vld_p1;
  logic                sync_p1;
  logic [15:0]         word_cnt_q;
  logic                use_pattern;
  logic [SW-1:0]       pattern;

`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
  logic [SW-1:0] pattern_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pattern_q <= '0;
    end else if (enable && resync) begin
      pattern_q <= '0;
    end else if (take) begin
      pattern_q <= pattern_q + SW'(1);
    end
  end

  assign use_pattern = test_pattern;
  assign pattern     = pattern_q;
`else
  logic unused_test_pattern;
  assign unused_test_pattern = test_pattern;
  assign use_pattern         = 1'b0;
  assign pattern             = '0;
`endif

  sample_select #(
    .NCH (NCH),
    .SW  (SW)
  ) u_select (
    .active_mode (active_mode_q),
    .in_i        (in_i),
    .in_q        (in_q),
    .use_pattern (use_pattern),
    .pattern     (pattern),
    .sample      (sample_lj),
    .bits        (bits)
  );

  // Stage p0: append the sample to the accumulator and extract a completed word.
  always_comb begin
    mode_norm = norm_mode(mode);
    resync    = (mode_norm != active_mode_q);
    rise      = !enable_q;
    take      = enable && !resync && in_valid;
    rshift    = 4'(SAMPLE_W) - bits;
    acc_next  = (acc_q << bits) | ACC_W'(sample_lj >> rshift);
    fill_sum  = {1'b0, fill_q} + {1'b0, bits};
    word_done = (fill_sum >= SUM_W'(WORD_W));
    // The oldest WORD_W of the fill_sum live bits sit just below bit fill_sum.
    word_p0   = WORD_W'(acc_next >> (fill_sum - SUM_W'(WORD_W)));
  end

  // Stage p1: registered word, strobe, restart pulse and word counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q         <= '0;
      fill_q        <= '0;
      active_mode_q <= MODE_2CH;
      enable_q      <= 1'b0;
      data_p1       <= '0;
      vld_p1        <= 1'b0;
      sync_p1       <= 1'b0;
      word_cnt_q    <= '0;
    end else begin
      enable_q <= enable;
      vld_p1   <= 1'b0;
      sync_p1  <= 1'b0;
      if (!enable) begin
        fill_q <= '0;
      end else if (resync) begin
        // Partial bits are abandoned; the next word starts from a fresh sample.
        fill_q        <= '0;
        acc_q         <= '0;
        active_mode_q <= mode_norm;
        sync_p1       <= 1'b1;
      end else begin
        sync_p1 <= rise;
        if (in_valid) begin
          acc_q <= acc_next;
          if (word_done) begin
            fill_q     <= FILL_W'(fill_sum - SUM_W'(WORD_W));
            data_p1    <= word_p0;
            vld_p1     <= 1'b1;
            word_cnt_q <= word_cnt_q + 16'd1;
          end else begin
            fill_q <= fill_sum[FILL_W-1:0];
          end
        end
      end
    end
  end

  assign out_data   = data_p1;
  assign out_en     = vld_p1;
  assign sync       = sync_p1;
  assign word_count = word_cnt_q;

endmodule

// File: tb/tb_sample_packer.sv
// Bench for sample_packer: bit-queue reference model checked every cycle, plus literal word checks.
module tb_sample_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  in_i;
  logic [5:0]  in_q;
  logic        in_valid;
  logic        enable;
  logic [1:0]  mode;
  logic        test_pattern;
  logic [15:0] out_data;
  logic        out_en;
  logic        sync;
  logic [15:0] word_count;

  always #5 clk = ~clk;

  sample_packer #(.NCH(3), .SW(2), .WORD_W(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_i         (in_i),
    .in_q         (in_q),
    .in_valid     (in_valid),
    .enable       (enable),
    .mode         (mode),
    .test_pattern (test_pattern),
    .out_data     (out_data),
    .out_en       (out_en),
    .sync         (sync),
    .word_count   (word_count)
  );

  // Reference model: a FIFO of bits; every 16 queued bits form one word.
  bit          mq[$];
  logic [1:0]  m_act     = 2'd1;
  logic        m_prev_en = 1'b0;
  logic [15:0] m_cnt     = 16'd0;
  logic [15:0] m_data    = 16'd0;
  logic        m_en      = 1'b0;
  logic        m_sync    = 1'b0;
  logic [1:0]  m_eff;
  logic [1:0]  fi;
  logic [1:0]  fq;
  logic [15:0] m_w;
  int          cyc = 0;
  int          preset_seq = 0;
  int          preset_seen = 0;
  logic [15:0] preset_val = 16'd0;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
  logic [1:0]  m_pat = 2'd0;
`endif

  always @(posedge clk) begin
    cyc++;
    if (preset_seq != preset_seen) begin
      preset_seen = preset_seq;
      m_cnt = preset_val;
    end
    m_en   = 1'b0;
    m_sync = 1'b0;
    if (!reset_n) begin
      mq.delete();
      m_act = 2'd1; m_prev_en = 1'b0; m_cnt = 16'd0; m_data = 16'd0;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
      m_pat = 2'd0;
`endif
    end else if (!enable) begin
      mq.delete();
      m_prev_en = 1'b0;
    end else begin
      m_eff = (mode == 2'd3) ? 2'd2 : mode;
      if (m_eff != m_act) begin
        m_act = m_eff;
        mq.delete();
        m_sync = 1'b1;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
        m_pat = 2'd0;
`endif
      end else begin
        m_sync = !m_prev_en;
        if (in_valid) begin
          for (int c = 0; c <= int'(m_act); c++) begin
            fi = in_i[2*c +: 2];
            fq = in_q[2*c +: 2];
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
            if (test_pattern) begin fi = m_pat; fq = m_pat; end
`endif
            mq.push_back(fi[1]); mq.push_back(fi[0]);
            mq.push_back(fq[1]); mq.push_back(fq[0]);
          end
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
          m_pat = m_pat + 2'd1;
`endif
          if (mq.size() >= 16) begin
            m_w = 16'd0;
            for (int k = 0; k < 16; k++) m_w = {m_w[14:0], mq.pop_front()};
            m_data = m_w;
            m_en   = 1'b1;
            m_cnt  = m_cnt + 16'd1;
          end
        end
      end
      m_prev_en = 1'b1;
    end
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_sync  = 0;
  logic [15:0] got_w[$];
  int          got_c[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Advance one cycle: compare at the falling edge, then move inputs just after it.
  task automatic step();
    @(negedge clk);
    chk("out_en",     {31'd0, out_en},     {31'd0, m_en});
    chk("sync",       {31'd0, sync},       {31'd0, m_sync});
    chk("word_count", {16'd0, word_count}, {16'd0, m_cnt});
    chk("out_data",   {16'd0, out_data},   {16'd0, m_data});
    if (out_en === 1'b1) begin
      got_w.push_back(out_data);
      got_c.push_back(cyc);
    end
    if (sync === 1'b1) n_sync++;
    #1;
  endtask

  task automatic set_in(input logic v, input logic [1:0] md, input logic [5:0] ii, input logic [5:0] qq);
    in_valid = v; mode = md; in_i = ii; in_q = qq;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk_word(input string name, input int idx, input logic [15:0] exp);
    chk(name, (idx < got_w.size()) ? {16'd0, got_w[idx]} : 32'hDEAD_BEEF, {16'd0, exp});
  endtask

  localparam logic [5:0] I6C  = 6'b001101;  // ch1 i=01, ch2 i=11
  localparam logic [5:0] Q6C  = 6'b000010;  // ch1 q=10, ch2 q=00
  localparam logic [5:0] IABC = 6'b111010;  // ch1 10, ch2 10, ch3 11
  localparam logic [5:0] QABC = 6'b001110;  // ch1 10, ch2 11, ch3 00
  localparam logic [5:0] ID   = 6'b101011;  // ch1 i=11, others junk
  localparam logic [5:0] QD   = 6'b110101;  // ch1 q=01, others junk

  int          base;
  int          s0;
  logic [15:0] wc_before;

  initial begin
    reset_n = 1'b0; enable = 1'b1; test_pattern = 1'b0;
    set_in(1'b0, 2'd1, 6'd0, 6'd0);
    run(2);
    chk("reset out_data",   {16'd0, out_data},   32'd0);
    chk("reset word_count", {16'd0, word_count}, 32'd0);
    chk("reset out_en",     {31'd0, out_en},     32'd0);
    reset_n = 1'b1;

    // Two-channel 0x6C samples
    base = got_w.size();
    set_in(1'b1, 2'd1, I6C, Q6C);
    run(4);
    set_in(1'b0, 2'd1, I6C, Q6C);
    run(1);
    chk("m1 nwords", got_w.size() - base, 2);
    chk_word("m1 w0", base, 16'h6C6C);
    chk_word("m1 w1", base + 1, 16'h6C6C);
    chk("m1 word_count", {16'd0, word_count}, 32'd2);

    // Three-channel 0xABC samples (first cycle is the resync, dropped)
    set_in(1'b1, 2'd2, IABC, QABC);
    run(1);
    base = got_w.size();
    run(8);
    set_in(1'b0, 2'd2, IABC, QABC);
    run(1);
    chk("m2 nwords", got_w.size() - base, 6);
    chk_word("m2 w0", base, 16'hABCA);
    chk_word("m2 w1", base + 1, 16'hBCAB);
    chk_word("m2 w2", base + 2, 16'hCABC);
    chk_word("m2 w3", base + 3, 16'hABCA);

    // One-channel 0xD, contiguous then every other cycle
    set_in(1'b1, 2'd0, ID, QD);
    test_pattern = 1'b1;
    run(1);
    base = got_w.size();
    run(8);
    chk("m0 nwords", got_w.size() - base, 2);
    chk_word("m0 w0", base, 16'hDDDD);
    chk_word("m0 w1", base + 1, 16'hDDDD);
    test_pattern = 1'b0;
    base = got_w.size();
    for (int k = 0; k < 16; k++) begin
      in_valid = (k % 2 == 0);
      step();
    end
    set_in(1'b0, 2'd0, ID, QD);
    run(1);
    chk("m0 gap nwords", got_w.size() - base, 2);
    chk_word("m0 gap w0", base, 16'hDDDD);
    chk("m0 gap spacing", (got_w.size() - base == 2) ? got_c[base+1] - got_c[base] : -1, 8);

    // Mode change mid-word discards the partial word
    set_in(1'b1, 2'd1, I6C, Q6C);
    run(2);
    base = got_w.size();
    s0 = n_sync;
    set_in(1'b1, 2'd2, IABC, QABC);
    run(5);
    set_in(1'b0, 2'd2, IABC, QABC);
    run(1);
    chk("resync syncs", n_sync - s0, 1);
    chk("resync nwords", got_w.size() - base, 3);
    chk_word("resync w0", base, 16'hABCA);
    chk_word("resync w2", base + 2, 16'hCABC);

    // Enable dropped mid-word
    set_in(1'b1, 2'd2, IABC, QABC);
    run(1);
    wc_before = m_cnt;
    base = got_w.size();
    s0 = n_sync;
    enable = 1'b0;
    run(3);
    chk("disable nwords", got_w.size() - base, 0);
    chk("disable word_count", {16'd0, word_count}, {16'd0, wc_before});
    enable = 1'b1;
    run(4);
    set_in(1'b0, 2'd2, IABC, QABC);
    run(1);
    chk("rise syncs", n_sync - s0, 1);
    chk("rise nwords", got_w.size() - base, 3);
    chk_word("rise w0", base, 16'hABCA);
    chk_word("rise w2", base + 2, 16'hCABC);

    // Word counter wrap
    force dut.word_cnt_q = 16'hFFFE;
    #1;
    release dut.word_cnt_q;
    preset_val = 16'hFFFE;
    preset_seq++;
    set_in(1'b1, 2'd2, IABC, QABC);
    run(4);
    set_in(1'b0, 2'd2, IABC, QABC);
    run(1);
    chk("wrap word_count", {16'd0, word_count}, 32'd1);

    // Reset mid-word
    set_in(1'b1, 2'd1, I6C, Q6C);
    run(2);
    reset_n = 1'b0;
    run(1);
    chk("rst out_data",   {16'd0, out_data},   32'd0);
    chk("rst word_count", {16'd0, word_count}, 32'd0);
    chk("rst out_en",     {31'd0, out_en},     32'd0);
    chk("rst sync",       {31'd0, sync},       32'd0);
    reset_n = 1'b1;
    base = got_w.size();
    run(2);
    set_in(1'b0, 2'd1, I6C, Q6C);
    run(1);
    chk("rst mode1 nwords", got_w.size() - base, 1);
    chk_word("rst mode1 w0", base, 16'h6C6C);

`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
    test_pattern = 1'b1;
    set_in(1'b1, 2'd0, ID, QD);
    run(1);
    base = got_w.size();
    run(4);
    set_in(1'b0, 2'd0, ID, QD);
    run(1);
    chk_word("pattern w0", base, 16'h05AF);
    test_pattern = 1'b0;
`endif

    // Randomized traffic checked against the model
    for (int k = 0; k < 3000; k++) begin
      reset_n  = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      in_valid     = ($urandom_range(0, 3) != 0);
      in_i         = 6'($urandom);
      in_q         = 6'($urandom);
      test_pattern = 1'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
